seq_arith_unit: RTL and testbench
=================================

# seq_arith_unit

Parametrised multi-cycle arithmetic unit; the sequential successor to the switch-selected combinational operand block. It takes two WIDTH-bit operands, selected from ROM by the top level, plus a 3-bit mode from the board switches. It computes a full-width product by shift-add, or quotient and remainder by restoring division, each over WIDTH cycles. A start/busy/done handshake to the top level replaces the fixed combinational path to the LEDs.

## Interface
- WIDTH, default 8: operand and result width; ≥ 2.
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; accepted only in IDLE.
- mode  input  3  operation select, sampled with start: 3'b101 MUL, 3'b110 DIV; all other codes NOP.
- op_a  input  WIDTH  multiplicand / dividend; sampled with start.
- op_b  input  WIDTH  multiplier / divisor; sampled with start.
- result_lo  output  WIDTH  product low half / quotient.
- result_hi  output  WIDTH  product high half / remainder.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse; results valid.
- err  output  1  divide-by-zero flag; held with results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch op_a, op_b and mode. Clear the iteration counter, accumulator and err.
  - MUL or DIV with op_b≠0 → RUN.
  - NOP → DONE with result_lo/result_hi = 0.
  - DIV with op_b=0 → DONE with result_lo = all ones, result_hi = op_a, err=1.
- RUN, MUL: each cycle examine the multiplier LSB. When it is 1, add the multiplicand into the high accumulator (WIDTH+1-bit sum, carry kept). Then shift {carry, acc_hi, acc_lo} right by one. Product is exact, 2·WIDTH bits, no overflow.
- RUN, DIV: each cycle shift {rem, quot} left by one and trial-subtract the divisor from rem using a WIDTH+1-bit subtract. When non-negative, keep the difference and set the quotient LSB to 1; otherwise restore rem and set it to 0. Unsigned only.
- RUN lasts exactly WIDTH cycles; counter width is $clog2(WIDTH+1). RUN → DONE on the last count.
- DONE: done=1 for one cycle → IDLE.
- result_lo, result_hi and err update only on entry to DONE. They hold until the next accepted start, then clear when that start is accepted.
- start while busy: ignored, no queuing, latched operands untouched.
- Operand and mode changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, result_lo=0, result_hi=0, busy=0, done=0, err=0.
- Cycle numbering: start sampled high at edge 0.
  - MUL/DIV: busy high from cycle 1. done high in cycle WIDTH+1 only (cycle 9 for WIDTH=8). busy low from cycle WIDTH+2.
  - NOP and divide-by-zero: done high in cycle 1, busy high in cycle 1 only.
- Back-to-back: start asserted during the done cycle is ignored. A new start is accepted at the first edge at which the state is IDLE.
- Throughput: one MUL/DIV per WIDTH+2 cycles.
- Reset mid-operation, any state: immediate abort, all outputs return to reset values, no done pulse.
- All outputs registered; no combinational path from any input to any output.

## Structure
- Package seq_arith_pkg:
  - MODE_MUL = 3'b101, MODE_DIV = 3'b110.
  - State enum {IDLE, RUN, DONE}.
- Sub-module addsub_n (parameter N): N-bit ripple adder/subtractor built from full-adder cells, with sub input, carry-in and carry-out. Instanced once with N = WIDTH+1, shared by MUL and DIV.
- Top: FSM, counter, accumulator/shift registers, output registers.

## Test plan
- WIDTH=8, MUL, 13×11 → done in cycle 9, result_lo=8'h8F, result_hi=8'h00, err=0. Also 200×3 → result_lo=8'h58, result_hi=8'h02. Also 255×255 → result_lo=8'h01, result_hi=8'hFE.
- DIV, 100÷16 → result_lo=8'h06, result_hi=8'h04. Also 7÷9 → result_lo=8'h00, result_hi=8'h07. Also 255÷1 → result_lo=8'hFF, result_hi=8'h00.
- DIV, 37÷0 → done in cycle 1, result_lo=8'hFF, result_hi=8'h25, err=1. The following MUL start clears err.
- mode=3'b000 with start → done in cycle 1, results 0. start held high while busy during a MUL → exactly one done, results from the first operands.
- rst pulsed in cycle 4 of a DIV → outputs 0 and busy=0 immediately, no done. A subsequent 50÷7 → result_lo=8'h07, result_hi=8'h01.
- WIDTH=16, MUL 16'hFFFF×16'h0002 → done in cycle 17, result_lo=16'hFFFE, result_hi=16'h0001.

Source files
------------

// File: rtl/seq_arith_pkg.sv
// Shared constants and state encoding for the sequential arithmetic unit.
package seq_arith_pkg;

    localparam logic [2:0] MODE_MUL = 3'b101;
    localparam logic [2:0] MODE_DIV = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple-carry adder/subtractor; sub inverts b so that a - b = a + ~b + 1
// when the caller also drives cin high.
module addsub_n #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] b_eff;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_inv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    // One full-adder cell per bit; the carry is rippled through a loop variable.
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ c;
            c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider with a
// start/busy/done handshake.
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [2:0]       mode_reg;
    logic [WIDTH-1:0] opnd_reg;   // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] hi_reg;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_reg;     // multiplier shifting out / quotient shifting in

    logic             is_div;
    logic             needs_run;
    logic             last_cnt;
    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] hi_next, lo_next;

    assign is_div    = (mode_reg == MODE_DIV);
    assign needs_run = (mode == MODE_MUL) || ((mode == MODE_DIV) && (op_b != '0));
    assign last_cnt  = (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = needs_run ? RUN : DONE;
            RUN:     if (last_cnt) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    // DIV feeds the shifted remainder {rem, quot msb}; MUL feeds {0, acc_hi}
    // and adds the multiplicand only when the multiplier LSB is set.
    always_comb begin
        if (is_div) begin
            add_a = {hi_reg, lo_reg[WIDTH-1]};
            add_b = {1'b0, opnd_reg};
        end else begin
            add_a = {1'b0, hi_reg};
            add_b = lo_reg[0] ? {1'b0, opnd_reg} : '0;
        end
    end

    addsub_n #(.N(WIDTH + 1)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (is_div),
        .cin  (is_div),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // For DIV, carry-out of the subtract means the difference is non-negative.
    always_comb begin
        if (is_div) begin
            hi_next = add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], add_cout};
        end else begin
            hi_next = add_sum[WIDTH:1];
            lo_next = {add_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            mode_reg  <= '0;
            opnd_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            result_lo <= '0;
            result_hi <= '0;
            err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg <= mode;
                        cnt_reg  <= '0;
                        hi_reg   <= '0;
                        err      <= 1'b0;
                        if (mode == MODE_DIV) begin
                            opnd_reg <= op_b;
                            lo_reg   <= op_a;
                        end else begin
                            opnd_reg <= op_a;
                            lo_reg   <= op_b;
                        end
                        if (!needs_run && (mode == MODE_DIV)) begin
                            result_lo <= '1;
                            result_hi <= op_a;
                            err       <= 1'b1;
                        end else begin
                            result_lo <= '0;
                            result_hi <= '0;
                        end
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    hi_reg  <= hi_next;
                    lo_reg  <= lo_next;
                    if (last_cnt) begin
                        result_lo <= lo_next;
                        result_hi <= hi_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit: WIDTH=8 instance for the bulk of the
// tests, WIDTH=16 instance for the wide multiply.
module tb_seq_arith_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [2:0]  mode  = '0;
    logic [7:0]  op_a  = '0;
    logic [7:0]  op_b  = '0;
    logic [7:0]  result_lo, result_hi;
    logic        busy, done, err;

    logic        start16 = 1'b0;
    logic [2:0]  mode16  = '0;
    logic [15:0] a16     = '0;
    logic [15:0] b16     = '0;
    logic [15:0] lo16, hi16;
    logic        busy16, done16, err16;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    seq_arith_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
        .result_lo(result_lo), .result_hi(result_hi), .busy(busy), .done(done), .err(err)
    );

    seq_arith_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16), .op_a(a16), .op_b(b16),
        .result_lo(lo16), .result_hi(hi16), .busy(busy16), .done(done16), .err(err16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result_lo", {24'd0, result_lo}, {24'd0, mon_e.lo});
                check("result_hi", {24'd0, result_hi}, {24'd0, mon_e.hi});
                check("err", {31'd0, err}, {31'd0, mon_e.err});
                $display("done: lo=%02h hi=%02h err=%0b", result_lo, result_hi, err);
            end
        end
    end

    // Call at a falling edge with the DUT idle; returns at a falling edge with it idle again.
    task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] elo, input logic [7:0] ehi, input logic eerr);
        int   lat;
        int   n;
        exp_t x;
        lat = ((m == 3'b101) || ((m == 3'b110) && (b != 8'd0))) ? 9 : 1;
        x.lo = elo; x.hi = ehi; x.err = eerr;
        sb.push_back(x);
        $display("op: mode=%03b a=%0d b=%0d expect lo=%02h hi=%02h err=%0b", m, a, b, elo, ehi, eerr);
        start = 1'b1; mode = m; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        mode = 3'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
        check("busy_c1", {31'd0, busy}, 32'd1);
        if (lat > 1) begin
            check("clr_lo", {24'd0, result_lo}, 32'd0);
            check("clr_hi", {24'd0, result_hi}, 32'd0);
            check("clr_err", {31'd0, err}, 32'd0);
        end
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, lat);
        @(negedge clk);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        int   n;
        int   nd0;
        logic [2:0]  m;
        logic [7:0]  a, b, elo, ehi;
        logic        eerr;
        logic [15:0] p;

        repeat (2) @(negedge clk);
        check("rst_lo", {24'd0, result_lo}, 32'd0);
        check("rst_hi", {24'd0, result_hi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b101, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0);
        run_op(3'b101, 8'd200, 8'd3, 8'h58, 8'h02, 1'b0);
        run_op(3'b101, 8'd255, 8'd255, 8'h01, 8'hFE, 1'b0);
        run_op(3'b110, 8'd100, 8'd16, 8'h06, 8'h04, 1'b0);
        run_op(3'b110, 8'd7, 8'd9, 8'h00, 8'h07, 1'b0);
        run_op(3'b110, 8'd255, 8'd1, 8'hFF, 8'h00, 1'b0);
        run_op(3'b110, 8'd37, 8'd0, 8'hFF, 8'h25, 1'b1);
        run_op(3'b101, 8'd6, 8'd7, 8'h2A, 8'h00, 1'b0);
        run_op(3'b000, 8'd5, 8'd9, 8'h00, 8'h00, 1'b0);

        // start held through the whole operation, operands changed mid-run
        x.lo = 8'hF0; x.hi = 8'h00; x.err = 1'b0;
        sb.push_back(x);
        $display("op: held start MUL 20x12");
        nd0 = n_done;
        start = 1'b1; mode = 3'b101; op_a = 8'd20; op_b = 8'd12;
        @(negedge clk);
        op_a = 8'd99; op_b = 8'd77;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("held_latency", n, 9);
        @(negedge clk);
        start = 1'b0;
        check("held_idle", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        check("held_one_done", n_done - nd0, 1);

        // reset in cycle 4 of a divide
        $display("op: DIV 200/3 aborted by reset");
        start = 1'b1; mode = 3'b110; op_a = 8'd200; op_b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_lo", {24'd0, result_lo}, 32'd0);
        check("abort_hi", {24'd0, result_hi}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op(3'b110, 8'd50, 8'd7, 8'h07, 8'h01, 1'b0);

        // random operations against a behavioural model
        for (int i = 0; i < 12; i++) begin
            m = 3'($urandom_range(0, 7));
            if (i % 3 == 0) m = 3'b101;
            if (i % 3 == 1) m = 3'b110;
            a = 8'($urandom);
            b = (i == 4) ? 8'd0 : 8'($urandom);
            elo = 8'd0; ehi = 8'd0; eerr = 1'b0;
            if (m == 3'b101) begin
                p = 16'(a) * 16'(b);
                elo = p[7:0]; ehi = p[15:8];
            end else if (m == 3'b110) begin
                if (b == 8'd0) begin
                    elo = 8'hFF; ehi = a; eerr = 1'b1;
                end else begin
                    elo = a / b; ehi = a % b;
                end
            end
            run_op(m, a, b, elo, ehi, eerr);
        end

        // WIDTH=16 multiply
        $display("op: W16 MUL FFFF x 0002");
        start16 = 1'b1; mode16 = 3'b101; a16 = 16'hFFFF; b16 = 16'h0002;
        @(negedge clk);
        start16 = 1'b0;
        n = 1;
        while (done16 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("w16_latency", n, 17);
        check("w16_lo", {16'd0, lo16}, 32'h0000FFFE);
        check("w16_hi", {16'd0, hi16}, 32'h00000001);
        check("w16_err", {31'd0, err16}, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
